axi_sram_slave: RTL

AXI3 responder (slave) backed by an on-chip word-addressed SRAM. It is the memory-side end of the 32-bit AXI3 bus that the `wired_sp` core drives as host, and it replaces the external chiplab RAM in standalone simulation and FPGA builds. It accepts one transaction at a time, with round-robin arbitration between reads and writes. It supports FIXED, INCR and (optionally) WRAP bursts of 1–16 beats.

---
 rtl/axi_sram_slave.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 responder backed by an on-chip word-addressed SRAM.
// Handles one transaction at a time. Reads and writes are arbitrated round-robin,
// and FIXED/INCR bursts of 1-16 beats are supported.
// Optional feature macro: AXI_SRAM_WRAP_EN adds WRAP burst support.
// When the macro is undefined, WRAP bursts are answered with SLVERR.
module axi_sram_slave #(
   parameter int ID_W      = 4,
   parameter int MEM_WORDS = 4096
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ID_W-1:0] arid,
   input  logic [31:0]     araddr,
   input  logic [7:0]      arlen,
   input  logic [2:0]      arsize,
   input  logic [1:0]      arburst,
   input  logic [1:0]      arlock,
   input  logic [3:0]      arcache,
   input  logic [2:0]      arprot,
   input  logic            arvalid,
   output logic            arready,
   output logic [ID_W-1:0] rid,
   output logic [31:0]     rdata,
   output logic [1:0]      rresp,
   output logic            rlast,
   output logic            rvalid,
   input  logic            rready,
   input  logic [ID_W-1:0] awid,
   input  logic [31:0]     awaddr,
   input  logic [7:0]      awlen,
   input  logic [2:0]      awsize,
   input  logic [1:0]      awburst,
   input  logic [1:0]      awlock,
   input  logic [3:0]      awcache,
   input  logic [2:0]      awprot,
   input  logic            awvalid,
   output logic            awready,
   input  logic [ID_W-1:0] wid,
   input  logic [31:0]     wdata,
   input  logic [3:0]      wstrb,
   input  logic            wlast,
   input  logic            wvalid,
   output logic            wready,
   output logic [ID_W-1:0] bid,
   output logic [1:0]      bresp,
   output logic            bvalid,
   input  logic            bready
);

   localparam int         IDX_W       = $clog2(MEM_WORDS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

   // An illegal size or burst type, or a WRAP burst with an unsupported length, is an error.
   function automatic logic is_err(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
      logic wrap_ok;
      logic e;
      wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      e = (size > 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
`ifndef AXI_SRAM_WRAP_EN
      e = e || (burst == 2'b10);
`endif
      return e;
   endfunction

   // Byte address of the next beat for the given burst type.
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] incr;
`ifdef AXI_SRAM_WRAP_EN
      logic [31:0] mask;
      mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
`else
      logic unused_len;
      unused_len = ^len;
`endif
      incr = a + (32'd1 << size);
      case (burst)
         2'b01:   next_addr = incr;
`ifdef AXI_SRAM_WRAP_EN
         2'b10:   next_addr = (a & ~mask) | (incr & mask);
`endif
         default: next_addr = a;
      endcase
   endfunction

   state_t            state;
   logic              prio_rd;
   logic [ID_W-1:0]   id_q;
   logic [31:0]       addr_q;
   logic [7:0]        len_q;
   logic [2:0]        size_q;
   logic [1:0]        burst_q;
   logic [7:0]        cnt_q;
   logic              err_q;
   logic              bad_q;
   logic [31:0]       mem [MEM_WORDS];

   logic              ar_err, aw_err, r_hs, w_hs, b_hs, beat_bad, rd_en, rd_err, mem_we;
   logic [31:0]       addr_nx;
   logic [IDX_W-1:0]  rd_idx, wr_idx;
   logic              unused_sideband;

   assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot};

   assign arready  = (state == IDLE) && arvalid && (!awvalid || prio_rd);
   assign awready  = (state == IDLE) && awvalid && (!arvalid || !prio_rd);
   assign wready   = (state == WR);
   assign r_hs     = rvalid && rready;
   assign w_hs     = wvalid && wready;
   assign b_hs     = bvalid && bready;
   assign ar_err   = is_err(arlen, arsize, arburst);
   assign aw_err   = is_err(awlen, awsize, awburst);
   assign addr_nx  = next_addr(addr_q, len_q, size_q, burst_q);
   assign beat_bad = (wlast != (cnt_q == len_q)) || (wid != id_q);

   // The first beat is read in the AR cycle; later beats are read in the R handshake cycle.
   assign rd_en    = arready || ((state == RD) && r_hs && !rlast);
   assign rd_idx   = arready ? araddr[2 +: IDX_W] : addr_nx[2 +: IDX_W];
   assign rd_err   = arready ? ar_err : err_q;
   assign wr_idx   = addr_q[2 +: IDX_W];
   assign mem_we   = w_hs && !err_q && !rst;

   // SRAM write port with byte enables.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Synchronous SRAM read. The output register holds its value while the beat is stalled.
   always_ff @(posedge clk) begin
      if (rst)        rdata <= 32'd0;
      else if (rd_en) rdata <= rd_err ? 32'd0 : mem[rd_idx];
   end

   // Transaction FSM: arbitration, beat counting, and registered response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         prio_rd <= 1'b1;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
         bad_q   <= 1'b0;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rresp   <= RESP_OKAY;
         rid     <= '0;
         bvalid  <= 1'b0;
         bresp   <= RESP_OKAY;
         bid     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arready) begin
                  id_q    <= arid;
                  addr_q  <= araddr;
                  len_q   <= arlen;
                  size_q  <= arsize;
                  burst_q <= arburst;
                  cnt_q   <= 8'd0;
                  err_q   <= ar_err;
                  prio_rd <= 1'b0;
                  rvalid  <= 1'b1;
                  rid     <= arid;
                  rlast   <= (arlen == 8'd0);
                  rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                  state   <= RD;
               end else if (awready) begin
                  id_q    <= awid;
                  addr_q  <= awaddr;
                  len_q   <= awlen;
                  size_q  <= awsize;
                  burst_q <= awburst;
                  cnt_q   <= 8'd0;
                  err_q   <= aw_err;
                  bad_q   <= 1'b0;
                  prio_rd <= 1'b1;
                  state   <= WR;
               end
            end
            RD: begin
               if (r_hs) begin
                  if (rlast) begin
                     rvalid <= 1'b0;
                     rlast  <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     cnt_q  <= cnt_q + 8'd1;
                     addr_q <= addr_nx;
                     rlast  <= ((cnt_q + 8'd1) == len_q);
                  end
               end
            end
            WR: begin
               if (w_hs) begin
                  cnt_q  <= cnt_q + 8'd1;
                  addr_q <= addr_nx;
                  bad_q  <= bad_q || beat_bad;
                  if (cnt_q == len_q) begin
                     bvalid <= 1'b1;
                     bid    <= id_q;
                     bresp  <= (err_q || bad_q || beat_bad) ? RESP_SLVERR : RESP_OKAY;
                     state  <= WRESP;
                  end
               end
            end
            WRESP: begin
               if (b_hs) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
